// File: rtl/knap_search.sv
// knap_search
// Exhaustive subset enumerator for the knapsack checker. After a start it
// issues every N_ITEMS-bit subset in ascending order, one per cycle. It
// lines the checker's verdicts up with the subset that produced them,
// using a CHK_LAT-deep tag pipeline, and accumulates three results: the
// number of valid subsets, the first valid subset and the valid subset
// with the highest value.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, abort, hold    launch, cancel and issue-stall controls
//   cand, cand_vld        candidate item-select vector and its issue strobe
//   chk_valid             checker verdict, CHK_LAT cycles after the issue
//   busy, done, aborted   status (busy in RUN/DRAIN) and one-cycle pulses
//   num_valid, first_set, best_set, best_value, best_found
//                         accumulated search results
module knap_search #(
  parameter int                       N_ITEMS     = 5,
  parameter int                       VAL_W       = 7,
  parameter logic [N_ITEMS*VAL_W-1:0] ITEM_VALUES = {7'd10, 7'd1, 7'd2, 7'd2, 7'd4},
  parameter int                       CHK_LAT     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               hold,
  output logic [N_ITEMS-1:0] cand,
  output logic               cand_vld,
  input  logic               chk_valid,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [N_ITEMS:0]   num_valid,
  output logic [N_ITEMS-1:0] first_set,
  output logic [N_ITEMS-1:0] best_set,
  output logic [VAL_W-1:0]   best_value,
  output logic               best_found
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DW = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;
  localparam logic [N_ITEMS-1:0] LAST_CAND  = {N_ITEMS{1'b1}};
  localparam logic [DW-1:0]      DRAIN_LAST = DW'((CHK_LAT > 0) ? (CHK_LAT - 1) : 0);

  state_t             state_r;
  state_t             state_s;
  logic [N_ITEMS-1:0] cnt_r;
  logic [DW-1:0]      drain_cnt_r;
  logic               start_go_s;
  logic               abort_go_s;
  logic               active_s;
  logic               last_issue_s;
  logic [N_ITEMS-1:0] al_set_s;
  logic               al_vld_s;
  logic               hit_s;
  logic [VAL_W-1:0]   tag_val_s;

  // Sum of the item values selected by a subset, at VAL_W bits.
  function automatic logic [VAL_W-1:0] subset_value(input logic [N_ITEMS-1:0] sel);
    logic [VAL_W-1:0] acc;
    acc = {VAL_W{1'b0}};
    for (int i = 0; i < N_ITEMS; i++) begin
      acc = acc + (sel[i] ? ITEM_VALUES[i*VAL_W +: VAL_W] : {VAL_W{1'b0}});
    end
    return acc;
  endfunction

  assign active_s     = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  // abort wins over start when both arrive together in IDLE
  assign start_go_s   = (state_r == ST_IDLE) && start && !abort;
  assign abort_go_s   = active_s && abort;
  // the candidate on the outputs right now is the final subset
  assign last_issue_s = (state_r == ST_RUN) && cand_vld && (cand == LAST_CAND);

  // Next-state selection.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_go_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (last_issue_s) begin
          state_s = (CHK_LAT > 0) ? ST_DRAIN : ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, status pulses and candidate issue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cand        <= {N_ITEMS{1'b0}};
      cand_vld    <= 1'b0;
      cnt_r       <= {N_ITEMS{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy        <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done        <= (state_s == ST_DONE);
      aborted     <= abort_go_s;
      drain_cnt_r <= (state_r == ST_DRAIN) ? (drain_cnt_r + {{(DW-1){1'b0}}, 1'b1}) : {DW{1'b0}};
      if (start_go_s) begin
        // subset 0 goes out in the cycle right after start; cnt_r is the next index
        cand     <= {N_ITEMS{1'b0}};
        cand_vld <= 1'b1;
        cnt_r    <= {{(N_ITEMS-1){1'b0}}, 1'b1};
      end else if ((state_r == ST_RUN) && !abort && !last_issue_s && !hold) begin
        cand     <= cnt_r;
        cand_vld <= 1'b1;
        cnt_r    <= cnt_r + {{(N_ITEMS-1){1'b0}}, 1'b1};
      end else begin
        cand_vld <= 1'b0;
      end
    end
  end

  generate
    if (CHK_LAT > 0) begin : g_tag_pipe
      logic [N_ITEMS-1:0] tag_set_r [CHK_LAT];
      logic               tag_vld_r [CHK_LAT];

      // Tag pipeline carrying issued subsets (and hold bubbles) to their verdicts.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < CHK_LAT; i++) begin
            tag_set_r[i] <= {N_ITEMS{1'b0}};
            tag_vld_r[i] <= 1'b0;
          end
        end else begin
          tag_set_r[0] <= cand;
          tag_vld_r[0] <= cand_vld && !abort_go_s;
          for (int i = 1; i < CHK_LAT; i++) begin
            tag_set_r[i] <= tag_set_r[i-1];
            // on abort, every tag still in flight is dropped
            tag_vld_r[i] <= tag_vld_r[i-1] && !abort_go_s;
          end
        end
      end

      assign al_set_s = tag_set_r[CHK_LAT-1];
      assign al_vld_s = tag_vld_r[CHK_LAT-1];
    end else begin : g_no_pipe
      assign al_set_s = cand;
      assign al_vld_s = cand_vld;
    end
  endgenerate

  assign tag_val_s = subset_value(al_set_s);
  // a verdict arriving in the same cycle as an accepted abort is discarded
  assign hit_s     = active_s && !abort && al_vld_s && chk_valid;

  // Result accumulation; cleared on launch, retained afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_valid  <= {(N_ITEMS+1){1'b0}};
      first_set  <= {N_ITEMS{1'b0}};
      best_set   <= {N_ITEMS{1'b0}};
      best_value <= {VAL_W{1'b0}};
      best_found <= 1'b0;
    end else if (start_go_s) begin
      num_valid  <= {(N_ITEMS+1){1'b0}};
      first_set  <= {N_ITEMS{1'b0}};
      best_set   <= {N_ITEMS{1'b0}};
      best_value <= {VAL_W{1'b0}};
      best_found <= 1'b0;
    end else if (hit_s) begin
      num_valid <= num_valid + {{N_ITEMS{1'b0}}, 1'b1};
      if (!best_found) begin
        first_set  <= al_set_s;
        best_found <= 1'b1;
      end
      // strict compare: on a tie the earlier (lower) subset is kept
      if (!best_found || (tag_val_s > best_value)) begin
        best_set   <= al_set_s;
        best_value <= tag_val_s;
      end
    end
  end

endmodule
